// File: rtl/deskew_pkg.sv
// deskew_collector shared helpers.
// Counter/pointer widths and lane slicing.
package deskew_pkg;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/deskew_lane.sv
// Free-running register chain of STAGES words.
// STAGES = 0 degenerates to a wire.
module deskew_lane #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (STAGES == 0) begin : g_wire
      logic unused_clk;
      assign unused_clk = clk ^ rst_n;
      assign q = d;
    end else begin : g_chain
      logic [WIDTH-1:0] r [STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < STAGES; i++)
            r[i] <= '0;
        end else begin
          r[0] <= d;
          for (int i = 1; i < STAGES; i++)
            r[i] <= r[i-1];
        end
      end

      assign q = r[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/deskew_collector.sv
// Realigns skewed lanes into whole words and
// queues them in a credit-guarded output FIFO.
module deskew_collector
  import deskew_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int LANES     = 5,
  parameter int OUT_DEPTH = 2
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [LANES*WIDTH-1:0] a_i,
  output logic [LANES*WIDTH-1:0] s_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   overflow_o
);

  localparam int CW = cnt_w(OUT_DEPTH);
  localparam int PW = ptr_w(OUT_DEPTH);
  localparam int WW = LANES * WIDTH;

  logic          accept;
  logic          wr;
  logic          pop;
  logic [WW-1:0] aligned;
  logic [CW-1:0] in_flight;
  logic [CW-1:0] count;
  logic [CW:0]   load;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [WW-1:0] mem [OUT_DEPTH];
  logic          overflow;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(OUT_DEPTH - 1)) ? '0
                                     : p + 1'b1;
  endfunction

  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      deskew_lane #(
        .WIDTH (WIDTH),
        .STAGES(LANES - 1 - k)
      ) u_lane (
        .clk  (clock_i),
        .rst_n(reset_n_i),
        .d    (a_i[lane_lo(k, WIDTH) +: WIDTH]),
        .q    (aligned[lane_lo(k, WIDTH) +: WIDTH])
      );
    end
  endgenerate

  // Marker travels with lane 0 and fires on the
  // cycle the last lane arrives.
  deskew_lane #(
    .WIDTH (1),
    .STAGES(LANES - 1)
  ) u_mark (
    .clk  (clock_i),
    .rst_n(reset_n_i),
    .d    (accept),
    .q    (wr)
  );

  assign load    = {1'b0, in_flight} + {1'b0, count};
  assign ready_o = load < (CW+1)'(OUT_DEPTH);
  assign accept  = valid_i & ready_o;
  assign valid_o = count != '0;
  assign pop     = valid_o & ready_i;
  assign s_o     = mem[rd_ptr];

  assign overflow_o = overflow;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      in_flight <= '0;
    end else if (accept && !wr) begin
      in_flight <= in_flight + 1'b1;
    end else if (!accept && wr) begin
      in_flight <= in_flight - 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count <= '0;
    end else if (wr && !pop) begin
      count <= count + 1'b1;
    end else if (!wr && pop) begin
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < OUT_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= aligned;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop)
        rd_ptr <= nxt(rd_ptr);
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i)
      overflow <= 1'b0;
    else if (valid_i && !ready_o)
      overflow <= 1'b1;
  end

endmodule
